cic_comp_fir: RTL



---
 rtl/cic_pkg.sv | 37 +++
 rtl/cic_sample_ring.sv | 53 +++++
 rtl/cic_comp_fir.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared types and helpers for the CIC compensation FIR
package cic_pkg;

   typedef enum logic [1:0] {IDLE, MAC, SCALE, OUT} fir_state_t;

   // Working width of sat_round; callers sign-extend into it and truncate out of it.
   localparam int SR_W = 128;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Round half up by frac bits, then clamp into a signed out_dw-bit range.
   function automatic logic signed [SR_W-1:0] sat_round(
      input logic signed [SR_W-1:0] acc,
      input int                     frac,
      input int                     out_dw
   );
      logic signed [SR_W-1:0] one;
      logic signed [SR_W-1:0] v;
      logic signed [SR_W-1:0] hi;
      logic signed [SR_W-1:0] lo;
      one = 1;
      v   = acc;
      if (frac > 0) v = v + (one <<< (frac - 1));
      v  = v >>> frac;
      hi = (one <<< (out_dw - 1)) - one;
      lo = -(one <<< (out_dw - 1));
      if (v > hi) v = hi;
      if (v < lo) v = lo;
      return v;
   endfunction

endpackage

// File: rtl/cic_sample_ring.sv
// rtl/cic_sample_ring.sv - circular sample buffer with tap-indexed combinational read
module cic_sample_ring
   import cic_pkg::*;
#(
   parameter int DW    = 32,
   parameter int DEPTH = 21,
   parameter int PW    = 5
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic [PW-1:0] rd_tap,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [PW-1:0] wptr_q;
   logic [PW-1:0] wptr_d;
   logic [PW:0]   newest;
   logic [PW:0]   idx;

   // Write the incoming sample at the pointer and advance it with wrap.
   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      if (wr_en) begin
         mem_d[wptr_q] = wr_data;
         wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      end
   end

   // Tap k is k samples older than the most recently written entry.
   always_comb begin
      newest = (wptr_q == '0) ? (PW+1)'(DEPTH - 1) : {1'b0, wptr_q} - 1'b1;
      if (newest >= {1'b0, rd_tap}) idx = newest - {1'b0, rd_tap};
      else                          idx = newest + ((PW+1)'(DEPTH) - {1'b0, rd_tap});
      rd_data = mem_q[PW'(idx)];
   end

   // Whole buffer clears at once on reset so no stale history leaks into a pass.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
      end
   end

endmodule

// File: rtl/cic_comp_fir.sv
// rtl/cic_comp_fir.sv - decimating CIC droop compensation FIR with one time-shared MAC
module cic_comp_fir
   import cic_pkg::*;
#(
   parameter int                          INP_DW    = 32,
   parameter int                          OUT_DW    = 32,
   parameter int                          COEF_DW   = 18,
   parameter int                          NUM_TAPS  = 21,
   parameter logic [COEF_DW*NUM_TAPS-1:0] COEFS     = '0,
   parameter int                          COEF_FRAC = 17,
   parameter int                          DECIM     = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [INP_DW-1:0] s_axis_in_tdata,
   input  logic              s_axis_in_tvalid,
   output logic [OUT_DW-1:0] m_axis_out_tdata,
   output logic              m_axis_out_tvalid,
   output logic              busy,
   output logic              overrun,
   input  logic              clear_overrun
);

   localparam int PW      = clog2(NUM_TAPS);
   localparam int PROD_DW = INP_DW + COEF_DW;
   localparam int ACC_DW  = PROD_DW + PW;

   if (!(DECIM == 1 || DECIM == 2) || NUM_TAPS < 2 || ACC_DW >= SR_W || OUT_DW >= SR_W) begin : g_bad_params
      $error("cic_comp_fir: unsupported DECIM, NUM_TAPS or widths");
   end

   fir_state_t                 state_q, state_d;
   logic [PW-1:0]              tap_q, tap_d;
   logic signed [ACC_DW-1:0]   acc_q, acc_d;
   logic                       phase_q, phase_d;
   logic [OUT_DW-1:0]          tdata_q, tdata_d;
   logic                       tvalid_q, tvalid_d;
   logic                       overrun_q, overrun_d;
   logic                       wr_en;
   logic [INP_DW-1:0]          ring_rd;
   logic [COEF_DW-1:0]         coef;
   logic signed [PROD_DW-1:0]  prod;

   cic_sample_ring #(
      .DW    (INP_DW),
      .DEPTH (NUM_TAPS),
      .PW    (PW)
   ) u_ring (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en),
      .wr_data (s_axis_in_tdata),
      .rd_tap  (tap_q),
      .rd_data (ring_rd)
   );

   // Sequencer: accept in IDLE, one tap per MAC cycle, scale, then a one-cycle strobe.
   always_comb begin
      state_d   = state_q;
      tap_d     = tap_q;
      acc_d     = acc_q;
      phase_d   = phase_q;
      tdata_d   = tdata_q;
      tvalid_d  = 1'b0;
      overrun_d = overrun_q;
      wr_en     = 1'b0;
      coef      = COEFS[COEF_DW*tap_q +: COEF_DW];
      prod      = $signed({{COEF_DW{ring_rd[INP_DW-1]}}, ring_rd})
                * $signed({{INP_DW{coef[COEF_DW-1]}}, coef});
      case (state_q)
         IDLE: begin
            if (s_axis_in_tvalid) begin
               wr_en = 1'b1;
               if (DECIM == 2) phase_d = ~phase_q;
               if (DECIM == 1 || !phase_q) begin
                  state_d = MAC;
                  acc_d   = '0;
                  tap_d   = '0;
               end
            end
         end
         MAC: begin
            acc_d = acc_q + ACC_DW'(prod);
            if (tap_q == PW'(NUM_TAPS - 1)) state_d = SCALE;
            else                            tap_d   = tap_q + 1'b1;
         end
         SCALE: begin
            tdata_d = OUT_DW'(sat_round(SR_W'(acc_q), COEF_FRAC, OUT_DW));
            state_d = OUT;
         end
         OUT: begin
            tvalid_d = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A drop outranks a simultaneous clear.
      if (clear_overrun) overrun_d = 1'b0;
      if (s_axis_in_tvalid && state_q != IDLE) overrun_d = 1'b1;
   end

   // State and datapath registers; reset aborts any pass in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         tap_q     <= '0;
         acc_q     <= '0;
         phase_q   <= 1'b0;
         tdata_q   <= '0;
         tvalid_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tap_q     <= tap_d;
         acc_q     <= acc_d;
         phase_q   <= phase_d;
         tdata_q   <= tdata_d;
         tvalid_q  <= tvalid_d;
         overrun_q <= overrun_d;
      end
   end

   assign m_axis_out_tdata  = tdata_q;
   assign m_axis_out_tvalid = tvalid_q;
   assign busy              = (state_q != IDLE);
   assign overrun           = overrun_q;

endmodule
